// File: rtl/esi_arr_tb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : esi_arr_tb_pkg
//  Description : Shared types, FSM encoding and helper functions for the
//                ESI array-sum drive/check block.
//  Revision    : 1.0 - initial release
// ============================================================================
package esi_arr_tb_pkg;

  typedef logic signed [12:0] si13_t;
  typedef logic        [23:0] ui24_t;

  // Element k of an array lives at bits [13k +: 13] (element 0 at the LSBs).
  typedef si13_t [3:0] arr4_si13_t;
  typedef ui24_t [1:0] arr2_ui24_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Pairwise sign-extended sum of the four 13-bit elements, kept modulo 2^24.
  function automatic arr2_ui24_t arr_sum_expected(input arr4_si13_t a);
    arr2_ui24_t res;
    for (int j = 0; j < 2; j++) begin
      res[j] = ui24_t'({{11{a[2*j][12]}},   a[2*j]}) +
               ui24_t'({{11{a[2*j+1][12]}}, a[2*j+1]});
    end
    return res;
  endfunction

  // Vector n of the stimulus sequence: element k = (seed + 4n + k) mod 2^13.
  function automatic arr4_si13_t arr_gen_vector(input logic [31:0] seed,
                                                input logic [31:0] n);
    arr4_si13_t v;
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w    = seed + (n << 2) + 32'(k);
      v[k] = w[12:0];
    end
    return v;
  endfunction

endpackage : esi_arr_tb_pkg
`default_nettype wire

// File: rtl/arr_sum_exp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : arr_sum_exp_fifo
//  Description : Synchronous FIFO of expected array-sum results. Pushes when
//                full and pops when empty are ignored. Reset clears the
//                pointers and the occupancy count; storage is not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module arr_sum_exp_fifo
  import esi_arr_tb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [47:0]                push_data,
  input  logic                       pop,
  output logic [47:0]                head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  arr2_ui24_t               r_mem [DEPTH];
  logic [c_PTR_W-1:0]       r_wr_ptr;
  logic [c_PTR_W-1:0]       r_rd_ptr;
  logic [c_CNT_W-1:0]       r_count;
  logic                     w_push_ok;
  logic                     w_pop_ok;

  assign full      = (r_count == c_DEPTH_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Storage write; DEPTH is a power of two so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push/pop leaves count alone.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : arr_sum_exp_fifo
`default_nettype wire

// File: rtl/arr_sum_drive_check.sv
`default_nettype none
// ============================================================================
//  Module      : arr_sum_drive_check
//  Description : Drives a deterministic stream of 4 x si13 vectors into an
//                array-sum block and checks the 2 x ui24 results it returns
//                against sums computed from the vectors sent. Counts vectors
//                sent, results accepted and errors (mismatched or unexpected
//                results). A zero-latency (combinational) summer is handled
//                by comparing against the vector being sent in the same cycle.
//  Options     : ARR_SUM_RAND_BP_EN - pseudo-random backpressure on the
//                result channel (ready asserted when a registered value in
//                0..100 exceeds 25).
//  Revision    : 1.0 - initial release
// ============================================================================
module arr_sum_drive_check
  import esi_arr_tb_pkg::*;
#(
  parameter int NUM_VECTORS = 16,
  parameter int SEED        = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  // Outbound vector stream
  output logic        arr_valid,
  input  logic        arr_ready,
  output logic [51:0] arr_data,
  // Inbound result stream
  input  logic        totalOut_valid,
  output logic        totalOut_ready,
  input  logic [47:0] totalOut_data,
  // Status
  output logic [31:0] sent_count,
  output logic [31:0] recv_count,
  output logic [31:0] err_count,
  output logic        done
);

  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] c_NUM_VEC = 32'(NUM_VECTORS);
  localparam logic [31:0] c_SEED    = 32'(SEED);
  localparam logic [31:0] c_CNT_MAX = '1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_idx;
  logic [31:0]        r_sent;
  logic [31:0]        r_recv;
  logic [31:0]        r_err;
  logic [31:0]        w_sent_nxt;
  logic [31:0]        w_recv_nxt;
  logic [31:0]        w_err_nxt;

  arr4_si13_t         w_vec;
  arr2_ui24_t         w_exp;
  logic [47:0]        w_cmp;
  logic [47:0]        w_fifo_head;
  logic [c_CNT_W-1:0] w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;

  logic               w_send_hs;
  logic               w_recv_hs;
  logic               w_bypass;
  logic               w_unexpected;
  logic               w_accept;
  logic               w_mismatch;
  logic               w_push;
  logic               w_pop;

  // Current vector and its expected sum depend only on the vector index,
  // so data stays stable while a send is stalled.
  assign w_vec    = arr_gen_vector(c_SEED, r_idx);
  assign w_exp    = arr_sum_expected(w_vec);
  assign arr_data = w_vec;

  assign w_send_hs    = arr_valid && arr_ready;
  assign w_recv_hs    = totalOut_valid && totalOut_ready;
  // Zero-latency result: compare against the vector leaving this cycle.
  assign w_bypass     = w_recv_hs && w_fifo_empty && w_send_hs;
  assign w_unexpected = w_recv_hs && w_fifo_empty && !w_send_hs;
  assign w_accept     = w_recv_hs && !w_unexpected;
  assign w_cmp        = w_fifo_empty ? w_exp : w_fifo_head;
  assign w_mismatch   = w_accept && (totalOut_data != w_cmp);
  assign w_push       = w_send_hs && !w_bypass && !w_fifo_full;
  assign w_pop        = w_accept && !w_fifo_empty;

  arr_sum_exp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_exp_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (w_push),
    .push_data (w_exp),
    .pop       (w_pop),
    .head      (w_fifo_head),
    .count     (w_fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // Next-state, saturating counter updates and channel/status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_sent_nxt  = r_sent;
    w_recv_nxt  = r_recv;
    w_err_nxt   = r_err;
    arr_valid   = 1'b0;
    done        = 1'b0;

    if (w_send_hs && (r_sent != c_CNT_MAX)) w_sent_nxt = r_sent + 32'd1;
    if (w_accept && (r_recv != c_CNT_MAX))  w_recv_nxt = r_recv + 32'd1;
    if ((w_unexpected || w_mismatch) && (r_err != c_CNT_MAX)) w_err_nxt = r_err + 32'd1;

    case (r_state)
      ST_RUN: begin
        arr_valid = rstn && (w_fifo_count < c_DEPTH_CNT);
        if (w_recv_nxt >= c_NUM_VEC)      w_state_nxt = ST_DONE;
        else if (w_sent_nxt >= c_NUM_VEC) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_recv_nxt >= c_NUM_VEC) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State, vector index and counter registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_RUN;
      r_idx   <= '0;
      r_sent  <= '0;
      r_recv  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sent  <= w_sent_nxt;
      r_recv  <= w_recv_nxt;
      r_err   <= w_err_nxt;
      if (w_send_hs) r_idx <= r_idx + 32'd1;
    end
  end

  assign sent_count = r_sent;
  assign recv_count = r_recv;
  assign err_count  = r_err;

`ifdef ARR_SUM_RAND_BP_EN
  logic [15:0] r_lfsr;
  logic [6:0]  r_rand;

  // Pseudo-random backpressure: registered value in 0..100, ready when > 25.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lfsr <= 16'hACE1;
      r_rand <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_rand <= 7'(r_lfsr % 16'd101);
    end
  end

  assign totalOut_ready = rstn && (r_rand > 7'd25);
`else
  assign totalOut_ready = rstn;
`endif

endmodule : arr_sum_drive_check
`default_nettype wire

// File: tb/tb_arr_sum_drive_check.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arr_sum_drive_check
//  Description : Bench for arr_sum_drive_check. u_main faces a registered
//                summer model with random handshakes, an optional fault, a
//                forced stall and spurious result pulses; u_wrap (SEED=4095)
//                faces a combinational summer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arr_sum_drive_check;

  localparam int N = 16;
  localparam logic [47:0] c_FLT = 48'h000001_000000;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        m_arr_valid, m_arr_ready;
  logic [51:0] m_arr_data;
  logic        m_tot_valid, m_tot_ready;
  logic [47:0] m_tot_data;
  logic [31:0] m_sent, m_recv, m_err;
  logic        m_done;

  logic        w_arr_valid, w_arr_ready;
  logic [51:0] w_arr_data;
  logic        w_tot_valid, w_tot_ready;
  logic [47:0] w_tot_data;
  logic [31:0] w_sent, w_recv, w_err;
  logic        w_done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [47:0] res_q[$];
  int          n_model;
  logic        fault, force_low, rand_en, spur_req, spur_now;

  // Vector n straight from the generation rule, using plain integer math.
  function automatic logic [51:0] model_vec(input int seed, input int n);
    logic [51:0] v;
    int x;
    for (int k = 0; k < 4; k++) begin
      x = (seed + 4 * n + k) % 8192;
      if (x < 0) x += 8192;
      v[13*k +: 13] = x[12:0];
    end
    return v;
  endfunction

  // Signed pairwise sums as integers, then truncated to 24 bits each.
  function automatic logic [47:0] model_sum(input logic [51:0] v);
    int e [4];
    int s0, s1;
    for (int k = 0; k < 4; k++) begin
      e[k] = int'(v[13*k +: 13]);
      if (e[k] >= 4096) e[k] -= 8192;
    end
    s0 = e[0] + e[1];
    s1 = e[2] + e[3];
    return {s1[23:0], s0[23:0]};
  endfunction

  // Combinational summer for the wrap instance.
  assign w_arr_ready = w_tot_ready;
  assign w_tot_valid = w_arr_valid;
  assign w_tot_data  = model_sum(w_arr_data);

  arr_sum_drive_check #(.NUM_VECTORS(N), .SEED(0), .FIFO_DEPTH(4)) u_main (
    .clk(clk), .rstn(rstn),
    .arr_valid(m_arr_valid), .arr_ready(m_arr_ready), .arr_data(m_arr_data),
    .totalOut_valid(m_tot_valid), .totalOut_ready(m_tot_ready), .totalOut_data(m_tot_data),
    .sent_count(m_sent), .recv_count(m_recv), .err_count(m_err), .done(m_done)
  );

  arr_sum_drive_check #(.NUM_VECTORS(N), .SEED(4095), .FIFO_DEPTH(4)) u_wrap (
    .clk(clk), .rstn(rstn),
    .arr_valid(w_arr_valid), .arr_ready(w_arr_ready), .arr_data(w_arr_data),
    .totalOut_valid(w_tot_valid), .totalOut_ready(w_tot_ready), .totalOut_data(w_tot_data),
    .sent_count(w_sent), .recv_count(w_recv), .err_count(w_err), .done(w_done)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of the registered summer model driving u_main.
  task automatic step();
    logic hs_s, hs_r, last_recv, hold;
    logic [51:0] d;
    @(negedge clk);
    hs_s      = m_arr_valid && m_arr_ready;
    hs_r      = m_tot_valid && m_tot_ready;
    d         = m_arr_data;
    last_recv = hs_r && !spur_now && (m_recv == 32'(N - 1));
    if (hs_s) check_val("send_data", 64'(d), 64'(model_vec(0, n_model)));
    if (last_recv) check_val("done_before_last", 64'(m_done), 64'd0);
    @(posedge clk);
    #1;
    if (last_recv) check_val("done_after_last", 64'(m_done), 64'd1);
    if (!rstn) begin
      res_q.delete();
      n_model     = 0;
      m_arr_ready = 1'b0;
      m_tot_valid = 1'b0;
      m_tot_data  = '0;
      spur_now    = 1'b0;
    end else begin
      hold = m_tot_valid && !hs_r && !spur_now;
      if (hs_r && !spur_now && res_q.size() > 0) void'(res_q.pop_front());
      if (hs_s) begin
        res_q.push_back(model_sum(d) ^ (fault ? c_FLT : 48'd0));
        n_model++;
      end
      m_arr_ready = force_low ? 1'b0 : (rand_en ? ($urandom_range(3, 0) != 0) : 1'b1);
      if (spur_req) begin
        spur_req    = 1'b0;
        spur_now    = 1'b1;
        m_tot_valid = 1'b1;
        m_tot_data  = 48'h1234_5678_9ABC;
      end else begin
        spur_now = 1'b0;
        if (res_q.size() > 0) begin
          m_tot_valid = hold || !rand_en || ($urandom_range(2, 0) != 0);
          m_tot_data  = res_q[0];
        end else begin
          m_tot_valid = 1'b0;
          m_tot_data  = '0;
        end
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    rstn = 1'b0;
    repeat (cycles) step();
    rstn = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!m_done && cyc < 3000) begin
      step();
      cyc++;
    end
    check_val({tag, "_done"}, 64'(m_done), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rstn = 1'b0; m_arr_ready = 1'b0; m_tot_valid = 1'b0; m_tot_data = '0;
    fault = 1'b0; force_low = 1'b0; rand_en = 1'b0; spur_req = 1'b0; spur_now = 1'b0;
    n_model = 0;

    // Reset held for 5 cycles
    repeat (5) step();
    check_val("rst_arr_valid", 64'(m_arr_valid), 64'd0);
    check_val("rst_tot_ready", 64'(m_tot_ready), 64'd0);
    check_val("rst_sent", 64'(m_sent), 64'd0);
    check_val("rst_recv", 64'(m_recv), 64'd0);
    check_val("rst_err", 64'(m_err), 64'd0);
    check_val("rst_done", 64'(m_done), 64'd0);
    check_val("rst_wrap_valid", 64'(w_arr_valid), 64'd0);
    rstn = 1'b1;
    #1;
    check_val("first_valid", 64'(m_arr_valid), 64'd1);
    check_val("first_data", 64'(m_arr_data), 64'(model_vec(0, 0)));
    check_val("first_tot_ready", 64'(m_tot_ready), 64'd1);
    check_val("wrap_first_data", 64'(w_arr_data), 64'(model_vec(4095, 0)));

    // Normal run with random handshakes
    rand_en = 1'b1;
    wait_done("norm");
    check_val("norm_sent", 64'(m_sent), 64'd16);
    check_val("norm_recv", 64'(m_recv), 64'd16);
    check_val("norm_err", 64'(m_err), 64'd0);
    check_val("norm_valid_after_done", 64'(m_arr_valid), 64'd0);
    check_val("wrap_done", 64'(w_done), 64'd1);
    check_val("wrap_sent", 64'(w_sent), 64'd16);
    check_val("wrap_recv", 64'(w_recv), 64'd16);
    check_val("wrap_err", 64'(w_err), 64'd0);

    // Faulty summer: one error per vector
    fault = 1'b1;
    do_reset(2);
    wait_done("fault");
    check_val("fault_err", 64'(m_err), 64'd16);
    check_val("fault_recv", 64'(m_recv), 64'd16);
    fault = 1'b0;

    // Stall the send channel for 10 cycles at vector 3
    rand_en = 1'b0;
    do_reset(2);
    cyc = 0;
    while (m_sent != 32'd3 && cyc < 50) begin
      step();
      cyc++;
    end
    check_val("stall_reach3", 64'(m_sent), 64'd3);
    force_low   = 1'b1;
    m_arr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("stall_valid", 64'(m_arr_valid), 64'd1);
      check_val("stall_data", 64'(m_arr_data), 64'(model_vec(0, 3)));
      check_val("stall_sent", 64'(m_sent), 64'd3);
    end
    force_low = 1'b0;
    wait_done("stall");
    check_val("stall_err", 64'(m_err), 64'd0);
    check_val("stall_recv", 64'(m_recv), 64'd16);

    // Spurious result while nothing is outstanding or being sent
    force_low = 1'b1;
    do_reset(2);
    step();
    spur_req = 1'b1;
    step();
    step();
    check_val("spur_err", 64'(m_err), 64'd1);
    check_val("spur_recv", 64'(m_recv), 64'd0);
    check_val("spur_sent", 64'(m_sent), 64'd0);
    force_low = 1'b0;

    // Reset in the middle of a run
    rand_en = 1'b1;
    do_reset(2);
    cyc = 0;
    while (m_sent < 32'd5 && cyc < 200) begin
      step();
      cyc++;
    end
    check_val("mid_reach5", 64'(m_sent >= 32'd5), 64'd1);
    rstn = 1'b0;
    step();
    check_val("mid_rst_sent", 64'(m_sent), 64'd0);
    check_val("mid_rst_recv", 64'(m_recv), 64'd0);
    check_val("mid_rst_err", 64'(m_err), 64'd0);
    check_val("mid_rst_valid", 64'(m_arr_valid), 64'd0);
    rstn = 1'b1;
    #1;
    check_val("mid_restart_data", 64'(m_arr_data), 64'(model_vec(0, 0)));
    wait_done("mid");
    check_val("mid_sent", 64'(m_sent), 64'd16);
    check_val("mid_err", 64'(m_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_arr_sum_drive_check
`default_nettype wire
